// File: rtl/panel_sequencer_if.sv
// Bus between the front-panel sequencer and its neighbours: CPU read strobe/address,
// debounced switch pulses and switch values in, jam byte and panel-write port out.
interface panel_sequencer_if;
    logic        run;
    logic        rd;
    logic [15:0] addr;
    logic        examine;
    logic        examine_next;
    logic        deposit;
    logic        deposit_next;
    logic [15:0] addr_sw;
    logic [7:0]  data_sw;
    logic [7:0]  data_out;
    logic        jam_en;
    logic        step_req;
    logic        pnl_we;
    logic [15:0] pnl_addr;
    logic [7:0]  pnl_data;
    logic [15:0] disp_addr;
    logic        busy;

    // Sequencer side
    modport slave (
        input  run, rd, addr, examine, examine_next, deposit, deposit_next, addr_sw, data_sw,
        output data_out, jam_en, step_req, pnl_we, pnl_addr, pnl_data, disp_addr, busy
    );

    // CPU / switch / memory side
    modport master (
        output run, rd, addr, examine, examine_next, deposit, deposit_next, addr_sw, data_sw,
        input  data_out, jam_en, step_req, pnl_we, pnl_addr, pnl_data, disp_addr, busy
    );
endinterface

// File: rtl/panel_sequencer.sv
// 8080 front-panel sequencer: jams JMP/NOP bytes on CPU reads to move the PC, latches the
// fetched address for display and issues single-cycle panel memory writes for DEPOSIT.
module panel_sequencer #(
    parameter logic [7:0] JMP_OP = 8'hC3,
    parameter logic [7:0] NOP_OP = 8'h00
) (
    input  logic               clk_i,
    input  logic               reset_i,
    panel_sequencer_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE, EX_OP, EX_LO, EX_HI, NX_OP, FETCH, DEP_WR
    } state_t;

    state_t      state_q;
    logic        rd_q;
    logic        dep_after_q;
    logic [7:0]  data_out_q;
    logic        jam_en_q;
    logic        step_req_q;
    logic        pnl_we_q;
    logic [15:0] pnl_addr_q;
    logic [7:0]  pnl_data_q;
    logic [15:0] disp_addr_q;

    logic rd_rise;
    logic rd_fall;
    assign rd_rise = bus.rd & ~rd_q;
    assign rd_fall = ~bus.rd & rd_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            rd_q        <= 1'b0;
            dep_after_q <= 1'b0;
            data_out_q  <= 8'h00;
            jam_en_q    <= 1'b0;
            step_req_q  <= 1'b0;
            pnl_we_q    <= 1'b0;
            pnl_addr_q  <= 16'h0000;
            pnl_data_q  <= 8'h00;
            disp_addr_q <= 16'h0000;
        end else begin
            rd_q     <= bus.rd;
            pnl_we_q <= 1'b0;
            if (state_q != IDLE && bus.run) begin
                // CPU took over: abandon the sequence, leave the display alone
                state_q     <= IDLE;
                dep_after_q <= 1'b0;
                data_out_q  <= 8'h00;
                jam_en_q    <= 1'b0;
                step_req_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!bus.run) begin
                            if (bus.examine) begin
                                data_out_q <= JMP_OP;
                                jam_en_q   <= 1'b1;
                                step_req_q <= 1'b1;
                                state_q    <= EX_OP;
                            end else if (bus.examine_next || bus.deposit_next) begin
                                dep_after_q <= bus.deposit_next & ~bus.examine_next;
                                data_out_q  <= NOP_OP;
                                jam_en_q    <= 1'b1;
                                step_req_q  <= 1'b1;
                                state_q     <= NX_OP;
                            end else if (bus.deposit) begin
                                state_q <= DEP_WR;
                            end
                        end
                    end
                    EX_OP: if (rd_fall) begin
                        data_out_q <= bus.addr_sw[7:0];
                        state_q    <= EX_LO;
                    end
                    EX_LO: if (rd_fall) begin
                        data_out_q <= bus.addr_sw[15:8];
                        state_q    <= EX_HI;
                    end
                    EX_HI, NX_OP: if (rd_fall) begin
                        data_out_q <= 8'h00;
                        jam_en_q   <= 1'b0;
                        state_q    <= FETCH;
                    end
                    FETCH: begin
                        if (rd_rise) disp_addr_q <= bus.addr;
                        if (rd_fall) begin
                            step_req_q <= 1'b0;
                            state_q    <= dep_after_q ? DEP_WR : IDLE;
                        end
                    end
                    DEP_WR: begin
                        pnl_we_q    <= 1'b1;
                        pnl_addr_q  <= disp_addr_q;
                        pnl_data_q  <= bus.data_sw;
                        dep_after_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.jam_en    = jam_en_q;
    assign bus.step_req  = step_req_q;
    assign bus.pnl_we    = pnl_we_q;
    assign bus.pnl_addr  = pnl_addr_q;
    assign bus.pnl_data  = pnl_data_q;
    assign bus.disp_addr = disp_addr_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
